mem_arbiter_mc: RTL and testbench
=================================

// Module: mem_arbiter_mc
// PURPOSE
//  N-channel arbitrating memory controller between requesters (IF, LSB, ...) and the
//  byte-wide RAM/hci port. Serialises 1..DATA_W/8-byte little-endian reads/writes into
//  byte cycles; fixed-priority or round-robin grant; read abort on flush; rdy pause.
// PARAMETERS
//  NCH      2   number of request channels (ch0 = IF, ch1 = LSB by convention)
//  ADDR_W   32  byte-address width
//  DATA_W   32  max transfer width; multiple of 8; NB = DATA_W/8 bytes
//  ARB_MODE 0   0 = fixed priority (lowest index wins); 1 = round-robin
//  LEN_W    3   width of each len field; must hold NB
// PORTS
//  clk        in   1            clock, all state on posedge
//  rst        in   1            asynchronous, active-low reset
//  rdy        in   1            global enable; low = pause
//  flush      in   1            abort in-progress read (mispredict)
//  req_valid  in   NCH          per-channel request, held until its done
//  req_we     in   NCH          1 = write, 0 = read
//  req_addr   in   NCH*ADDR_W   start byte address, ch i at [i*ADDR_W +: ADDR_W]
//  req_len    in   NCH*LEN_W    byte count 1..NB
//  req_wdata  in   NCH*DATA_W   write data, byte k at [8k+7:8k]
//  done       out  NCH          one-hot, one-cycle completion pulse
//  rdata      out  DATA_W       read data, valid while done of a read is high
//  busy       out  1            state != IDLE
//  mem_din    in   8            RAM read byte (1-cycle latency after mem_a)
//  mem_dout   out  8            RAM write byte
//  mem_a      out  ADDR_W       RAM byte address
//  mem_wr     out  1            1 = write this cycle
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, done=0, rdata=0, busy=0, mem_wr=0, mem_a=0,
//   mem_dout=0, rr pointer=0. Takes effect immediately, mid-transfer included.
//  States: IDLE -> READ | WRITE -> DONE -> IDLE.
//  IDLE: at edge t, if any req_valid: pick winner (ARB_MODE 0: lowest index; 1: first
//   set at or after rr pointer, wrapping), latch ch/we/addr/len/wdata, rdata<=0.
//   RR pointer <= winner+1 mod NCH on every grant.
//  READ (len L): cycles t..t+L-1 drive mem_a=addr+k, mem_wr=0. Byte k sampled from
//   mem_din at edge t+k+2 into rdata[8k+7:8k]. Last capture at t+L+1 -> DONE.
//   Bytes >= L read as 0 (no sign extension; requester handles).
//  WRITE: cycles t..t+L-1 drive mem_wr=1, mem_a=addr+k, mem_dout=wdata byte k;
//   -> DONE at edge t+L.
//  DONE: done[ch]=1 for exactly this cycle; no sampling; -> IDLE. New request
//   granted at earliest one edge later (requester drops valid on seeing done).
//  Address arithmetic modulo 2^ADDR_W (0xFFFFFFFF+1 = 0).
//  len 0 or > NB is illegal; treated as NB.
//  mem_wr=0 and mem_a=0 in IDLE and DONE.
//  flush=1 in READ: -> IDLE at that edge, no done, captured data discarded.
//   flush in WRITE or DONE ignored: writes always complete.
//   flush in IDLE: requests still sampled normally.
//  rdy=0: all state frozen, mem_wr forced 0.
//   Byte issued but not captured is discarded; its address is re-issued on the
//   first rdy=1 cycle, so READ latency grows by pause length + 1.
//   WRITE resumes at the unwritten byte.
//  flush and rdy=0 together: flush wins.
//  Simultaneous requests never produce two done bits.
// TESTING
//  1 RAM[0x100..103]=11 22 33 44, ch0 read len4 -> mem_a 100..103 over 4 cycles,
//    rdata=0x44332211, done=2'b01 one cycle, at t+5
//  2 ch1 write len2 addr 0x200 wdata 0xABCD -> (wr,a,dout)=(1,200,CD),(1,201,AB),
//    done=2'b10 at t+2, RAM updated
//  3 ch0+ch1 held continuously: ARB_MODE0 -> grants 0,0,0..;
//    ARB_MODE1 -> grants 0,1,0,1
//  4 flush 2 cycles into ch0 read len4 -> no done, mem_wr 0, next ch1 read correct;
//    flush during write -> write completes, done
//  5 rdy=0 for 3 cycles mid read len4 -> rdata still 0x44332211, done at t+5+4;
//    write paused -> no mem_wr during pause
//  6 read len2 at 0xFFFFFFFF -> second mem_a=0; rst low mid-write -> mem_wr=0,
//    done=0 immediately

Source files
------------

// File: rtl/mem_arbiter_mc_if.sv
// Request/response and byte-wide RAM signals between requesters and mem_arbiter_mc.
// Channel i fields sit at [i*W +: W] of each flattened request vector.
interface mem_arbiter_mc_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 3
);
    logic [NCH-1:0]        req_valid;
    logic [NCH-1:0]        req_we;
    logic [NCH*ADDR_W-1:0] req_addr;
    logic [NCH*LEN_W-1:0]  req_len;
    logic [NCH*DATA_W-1:0] req_wdata;
    logic [NCH-1:0]        done;
    logic [DATA_W-1:0]     rdata;
    logic                  busy;
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_W-1:0]     mem_a;
    logic                  mem_wr;

    modport master (
        output req_valid, req_we, req_addr, req_len, req_wdata, mem_din,
        input  done, rdata, busy, mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len, req_wdata, mem_din,
        output done, rdata, busy, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter_mc.sv
// N-channel arbiter serialising multi-byte little-endian transfers onto a byte-wide RAM port.
// Reads are pipelined (issue one byte per cycle, capture two edges later); writes go one byte per cycle.
module mem_arbiter_mc #(
    parameter int NCH      = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int LEN_W    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    mem_arbiter_mc_if.slave bus
);
    localparam int NB   = DATA_W / 8;
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam bit RR   = (ARB_MODE == 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

    state_t            state_q, state_d;
    xfer_t             xfer_q, xfer_d, sel;
    logic              sel_we;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic              infl_q, infl_d;
    logic              gnt_found;
    logic [CH_W-1:0]   gnt_ch;
    logic [LEN_W:0]    issue_n;
    logic              issue;

    // Round-robin: first pass looks at/after the pointer, second pass wraps to the lowest index.
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!gnt_found && bus.req_valid[c] && (!RR || CH_W'(c) >= rr_q)) begin
                gnt_found = 1'b1;
                gnt_ch    = CH_W'(c);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (!gnt_found && bus.req_valid[c]) begin
                gnt_found = 1'b1;
                gnt_ch    = CH_W'(c);
            end
        end
    end

    always_comb begin
        sel    = '0;
        sel_we = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (CH_W'(c) == gnt_ch) begin
                sel_we    = bus.req_we[c];
                sel.addr  = bus.req_addr[c*ADDR_W +: ADDR_W];
                sel.len   = bus.req_len[c*LEN_W +: LEN_W];
                sel.wdata = bus.req_wdata[c*DATA_W +: DATA_W];
            end
        end
        sel.ch = gnt_ch;
        if (sel.len == '0 || int'(sel.len) > NB)
            sel.len = LEN_W'(NB);
    end

    // Next read byte to put on the bus: everything captured plus the one currently in flight.
    assign issue_n = {1'b0, idx_q} + {{LEN_W{1'b0}}, infl_q};
    assign issue   = (issue_n < {1'b0, xfer_q.len});

    always_comb begin
        state_d      = state_q;
        xfer_d       = xfer_q;
        rr_d         = rr_q;
        rdata_d      = rdata_q;
        idx_d        = idx_q;
        infl_d       = infl_q;
        bus.mem_a    = '0;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = '0;

        case (state_q)
            S_IDLE: begin
                if (rdy && gnt_found) begin
                    xfer_d  = sel;
                    rdata_d = '0;
                    idx_d   = '0;
                    infl_d  = 1'b0;
                    rr_d    = (gnt_ch == CH_W'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
                    state_d = sel_we ? S_WRITE : S_READ;
                end
            end

            S_READ: begin
                if (issue)
                    bus.mem_a = xfer_q.addr + ADDR_W'(issue_n);
                if (flush) begin
                    infl_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (!rdy) begin
                    // The RAM answer for the in-flight byte is lost while paused; re-issue it on resume.
                    infl_d = 1'b0;
                end else begin
                    if (infl_q) begin
                        for (int b = 0; b < NB; b++)
                            if (LEN_W'(b) == idx_q)
                                rdata_d[8*b +: 8] = bus.mem_din;
                        idx_d = idx_q + 1'b1;
                        if (idx_q + 1'b1 == xfer_q.len)
                            state_d = S_DONE;
                    end
                    infl_d = issue;
                end
            end

            S_WRITE: begin
                bus.mem_a  = xfer_q.addr + ADDR_W'(idx_q);
                bus.mem_wr = rdy;
                for (int b = 0; b < NB; b++)
                    if (LEN_W'(b) == idx_q)
                        bus.mem_dout = xfer_q.wdata[8*b +: 8];
                if (rdy) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == xfer_q.len - 1'b1)
                        state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (rdy)
                    state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            xfer_q  <= '0;
            rr_q    <= '0;
            rdata_q <= '0;
            idx_q   <= '0;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xfer_q  <= xfer_d;
            rr_q    <= rr_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
            infl_q  <= infl_d;
        end
    end

    always_comb begin
        bus.done = '0;
        for (int c = 0; c < NCH; c++)
            if (state_q == S_DONE && xfer_q.ch == CH_W'(c))
                bus.done[c] = 1'b1;
    end

    assign bus.busy  = (state_q != S_IDLE);
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_mem_arbiter_mc.sv
// Directed bench for mem_arbiter_mc: a fixed-priority instance on a 4 KiB byte RAM model
// and a round-robin instance used for the grant-order checks.
module tb_mem_arbiter_mc;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rdy   = 1'b1;
    logic flush = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;
    logic [7:0] ram [0:4095];
    logic [1:0] seq0 [4];
    logic [1:0] seq1 [4];
    int   n0, n1;

    mem_arbiter_mc_if #(.NCH(2), .ADDR_W(32), .DATA_W(32), .LEN_W(3)) bus ();
    mem_arbiter_mc_if #(.NCH(2), .ADDR_W(32), .DATA_W(32), .LEN_W(3)) bus_rr ();

    mem_arbiter_mc #(.NCH(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .LEN_W(3)) u_dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus)
    );
    mem_arbiter_mc #(.NCH(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .LEN_W(3)) u_rr (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus_rr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
        bus.mem_din    <= ram[bus.mem_a[11:0]];
        bus_rr.mem_din <= bus_rr.mem_a[7:0];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic we, input logic [31:0] addr,
                           input logic [2:0] len, input logic [31:0] wd);
        bus.req_we[ch]              = we;
        bus.req_addr[ch*32 +: 32]   = addr;
        bus.req_len[ch*3 +: 3]      = len;
        bus.req_wdata[ch*32 +: 32]  = wd;
        bus.req_valid[ch]           = 1'b1;
    endtask

    // Starts at a negedge; cycle index cyc counts negedges after the grant edge.
    task automatic xfer(input string tag, input int ch, input logic we, input logic [31:0] addr,
                        input logic [2:0] len, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input int exp_lat, input int pause_at, input int pause_n, input int flush_at);
        int ln;
        bit got_done;
        got_done = 1'b0;
        ln = (len == 3'd0 || len > 3'd4) ? 4 : int'(len);
        set_req(ch, we, addr, len, wd);
        for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
            @(negedge clk);
            if (!rdy && we) chk({tag, "/wr_pause"}, 32'(bus.mem_wr), 32'h0);
            if (pause_n == 0 && cyc < ln) begin
                chk({tag, "/a"}, bus.mem_a, addr + 32'(cyc));
                chk({tag, "/wr"}, 32'(bus.mem_wr), 32'(we));
                if (we) chk({tag, "/dout"}, 32'(bus.mem_dout), (wd >> (8*cyc)) & 32'hFF);
            end
            if (bus.done != 2'b00) begin
                got_done = 1'b1;
                chk({tag, "/lat"}, 32'(cyc), 32'(exp_lat));
                chk({tag, "/done"}, 32'(bus.done), 32'(1) << ch);
                if (!we) chk({tag, "/rdata"}, bus.rdata, exp_rd);
                bus.req_valid[ch] = 1'b0;
            end
            flush = (cyc == flush_at);
            rdy   = !(cyc >= pause_at && cyc < pause_at + pause_n);
        end
        if (!got_done) begin
            chk({tag, "/timeout"}, 32'h0, 32'h1);
            bus.req_valid[ch] = 1'b0;
        end
        flush = 1'b0;
        rdy   = 1'b1;
        @(negedge clk);
        chk({tag, "/done_clr"}, 32'(bus.done), 32'h0);
        chk({tag, "/idle"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_len = '0; bus.req_wdata = '0;
        bus_rr.req_valid = '0; bus_rr.req_we = '0; bus_rr.req_addr = '0;
        bus_rr.req_len = '0; bus_rr.req_wdata = '0;
        for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
        #1;
        ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22; ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
        ram[12'hFFF] <= 8'hEE; ram[12'h000] <= 8'h5C;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_wr", 32'(bus.mem_wr), 32'h0);
        chk("rst_a", bus.mem_a, 32'h0);
        chk("rst_dout", 32'(bus.mem_dout), 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        xfer("t1_rd4", 0, 1'b0, 32'h100, 3'd4, 32'h0, 32'h44332211, 5, -1, 0, -1);
        xfer("t2_wr2", 1, 1'b1, 32'h200, 3'd2, 32'hABCD, 32'h0, 2, -1, 0, -1);
        chk("t2_ram0", 32'(ram[12'h200]), 32'hCD);
        chk("t2_ram1", 32'(ram[12'h201]), 32'hAB);
        chk("t2_ram2", 32'(ram[12'h202]), 32'h00);
        xfer("len0", 0, 1'b0, 32'h100, 3'd0, 32'h0, 32'h44332211, 5, -1, 0, -1);
        xfer("len1", 1, 1'b0, 32'h102, 3'd1, 32'h0, 32'h00000033, 2, -1, 0, -1);
        xfer("len7", 1, 1'b0, 32'h101, 3'd7, 32'h0, 32'h00443322, 5, -1, 0, -1);

        // Both channels held continuously on both instances.
        for (int i = 0; i < 4; i++) begin seq0[i] = 2'b00; seq1[i] = 2'b00; end
        n0 = 0; n1 = 0;
        set_req(0, 1'b0, 32'h100, 3'd1, 32'h0);
        set_req(1, 1'b0, 32'h100, 3'd1, 32'h0);
        bus_rr.req_we = 2'b00; bus_rr.req_len = {3'd1, 3'd1};
        bus_rr.req_addr = {32'h10, 32'h20}; bus_rr.req_valid = 2'b11;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done != 2'b00) begin
                chk("t3_1hot_fix", 32'($countones(bus.done)), 32'h1);
                if (n0 < 4) begin seq0[n0] = bus.done; n0++; end
            end
            if (bus_rr.done != 2'b00) begin
                chk("t3_1hot_rr", 32'($countones(bus_rr.done)), 32'h1);
                if (n1 < 4) begin seq1[n1] = bus_rr.done; n1++; end
            end
        end
        bus.req_valid = 2'b00; bus_rr.req_valid = 2'b00;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t3_fixed", 32'(seq0[i]), 32'h1);
            chk("t3_rr", 32'(seq1[i]), (i % 2 == 1) ? 32'h2 : 32'h1);
        end

        set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
        @(negedge clk);
        chk("t4_busy", 32'(bus.busy), 32'h1);
        @(negedge clk);
        flush = 1'b1;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t4_fl_busy", 32'(bus.busy), 32'h0);
        chk("t4_fl_done", 32'(bus.done), 32'h0);
        chk("t4_fl_wr", 32'(bus.mem_wr), 32'h0);
        flush = 1'b0;
        @(negedge clk);
        chk("t4_fl_done2", 32'(bus.done), 32'h0);
        xfer("t4_rd_ch1", 1, 1'b0, 32'h100, 3'd4, 32'h0, 32'h44332211, 5, -1, 0, -1);
        xfer("t4_wr_fl", 0, 1'b1, 32'h310, 3'd3, 32'h00332211, 32'h0, 3, -1, 0, 1);
        chk("t4_ram", {8'h0, ram[12'h312], ram[12'h311], ram[12'h310]}, 32'h00332211);

        xfer("t5_rd_pause", 0, 1'b0, 32'h100, 3'd4, 32'h0, 32'h44332211, 9, 2, 3, -1);
        xfer("t5_wr_pause", 1, 1'b1, 32'h300, 3'd4, 32'hDDCCBBAA, 32'h0, 7, 1, 3, -1);
        chk("t5_ram", {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]}, 32'hDDCCBBAA);

        xfer("t6_wrap", 0, 1'b0, 32'hFFFFFFFF, 3'd2, 32'h0, 32'h00005CEE, 3, -1, 0, -1);
        set_req(0, 1'b1, 32'h400, 3'd4, 32'h04030201);
        @(negedge clk);
        chk("t6_pre_wr", 32'(bus.mem_wr), 32'h1);
        rst = 1'b0;
        #1;
        chk("t6_rst_wr", 32'(bus.mem_wr), 32'h0);
        chk("t6_rst_done", 32'(bus.done), 32'h0);
        chk("t6_rst_busy", 32'(bus.busy), 32'h0);
        chk("t6_rst_a", bus.mem_a, 32'h0);
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_idle", 32'(bus.busy), 32'h0);
        chk("t6_ram", 32'(ram[12'h400]), 32'h00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
